aoi_req_sched: RTL and testbench

- Scheduler that shares the registered 4-bit AOI22 datapath between NUM_REQ requesters.
- AOI22 function: out = ~((in[0]&in[1])|(in[2]&in[3])).
- Picks one pending request round-robin, drives the datapath input, waits the datapath latency, then returns the 1-bit result to the winner.
- Also computes the expected AOI22 value and flags datapath mismatches.
- Sits between the input-source logic and the AOI datapath instance.

---
 rtl/aoi_pkg.sv | 18 +
 rtl/aoi_req_sched_rr_arbiter.sv | 29 ++
 rtl/aoi_req_sched.sv | 118 +++++++++++
 tb/tb_aoi_req_sched.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aoi_pkg.sv
// Shared definitions for the AOI22 request scheduler: FSM encoding,
// datapath operand width and the reference AOI22 function.
package aoi_pkg;

  localparam int AOI_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Expected AOI22 output for one 4-bit operand.
  function automatic logic aoi22_ref(input logic [AOI_W-1:0] d);
    return ~((d[0] & d[1]) | (d[2] & d[3]));
  endfunction

endpackage

// File: rtl/aoi_req_sched_rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr+1 upward, wrapping,
// and grants the first pending requester.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               any
);

  logic [PTR_W-1:0] idx;

  // Scan requesters in rotated priority order, keep the first hit.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = PTR_W'((int'(ptr) + off) % NUM_REQ);
      if (!any && req[idx]) begin
        grant[idx] = 1'b1;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aoi_req_sched.sv
// Shares one registered AOI22 datapath between NUM_REQ requesters.
// Accepts one request round-robin, waits LAT edges, returns the sampled
// result to the winner and flags any disagreement with the expected value.
module aoi_req_sched
  import aoi_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int LAT     = 1,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [AOI_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic                     resp_data,
  output logic [AOI_W-1:0]         dp_in,
  input  logic                     dp_out,
  output logic                     busy,
  output logic                     chk_err,
  output logic [CNT_W-1:0]         err_cnt
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int LAT_W = $clog2(LAT + 1);

  state_t             state, next_state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   win_idx;
  logic [LAT_W-1:0]   cnt;
  logic               exp_bit;
  logic [NUM_REQ-1:0] grant;
  logic               any_req;
  logic               accept;
  logic               sample;
  logic [AOI_W-1:0]   win_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .any   (any_req)
  );

  // Convert the one-hot grant into an index and pick the winner's operand.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) win_idx = PTR_W'(i);
    end
    win_data = req_data[AOI_W*win_idx +: AOI_W];
  end

  assign accept = (state == IDLE) && !rst && any_req;
  assign sample = (state == WAIT) && (cnt == LAT_W'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic: IDLE -> WAIT on accept, WAIT -> RESP on last count, RESP -> IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = WAIT;
      WAIT:    if (sample) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs: ready only to the arbiter's pick while idle and out of reset.
  always_comb begin
    busy      = (state != IDLE);
    req_ready = accept ? grant : '0;
  end

  // Transaction registers: operand launch, latency count, result capture and checker.
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_in      <= '0;
      resp_valid <= '0;
      resp_data  <= 1'b0;
      chk_err    <= 1'b0;
      err_cnt    <= '0;
      ptr        <= PTR_W'(NUM_REQ - 1);
      cnt        <= '0;
      grant_idx  <= '0;
      exp_bit    <= 1'b0;
    end else begin
      resp_valid <= '0;
      if (accept) begin
        dp_in     <= win_data;
        ptr       <= win_idx;
        grant_idx <= win_idx;
        exp_bit   <= aoi22_ref(win_data);
        cnt       <= LAT_W'(LAT);
      end
      if (state == WAIT) cnt <= cnt - LAT_W'(1);
      if (sample) begin
        resp_data             <= dp_out;
        resp_valid[grant_idx] <= 1'b1;
        if (dp_out != exp_bit) begin
          chk_err <= 1'b1;
          if (err_cnt != {CNT_W{1'b1}}) err_cnt <= err_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_aoi_req_sched.sv
// Randomized scoreboard bench for aoi_req_sched with a latency-LAT datapath
// stand-in that can be switched to produce inverted results.
module tb_aoi_req_sched;
  import aoi_pkg::*;

  localparam int NREQ = 3;
  localparam int TLAT = 3;
  localparam int TCW  = 2;
  localparam int SAT  = (1 << TCW) - 1;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [4*NREQ-1:0]     req_data;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       resp_valid;
  logic                  resp_data;
  logic [3:0]            dp_in;
  logic                  dp_out;
  logic                  busy;
  logic                  chk_err;
  logic [TCW-1:0]        err_cnt;

  aoi_req_sched #(
    .NUM_REQ (NREQ),
    .LAT     (TLAT),
    .CNT_W   (TCW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .dp_in      (dp_in),
    .dp_out     (dp_out),
    .busy       (busy),
    .chk_err    (chk_err),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath stand-in: result of dp_in becomes sampleable TLAT edges after it changes.
  logic [3:0] pipe [0:TLAT-2];
  bit inv = 1'b0;
  always @(posedge clk) begin
    pipe[0] <= dp_in;
    for (int k = 1; k < TLAT - 1; k++) pipe[k] <= pipe[k-1];
  end
  assign dp_out = aoi22_ref(pipe[TLAT-2]) ^ inv;

  typedef struct {
    int idx;
    bit val;
    int due;
    bit mis;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_ptr = NREQ - 1;
  int free_edge = 0;
  int m_err = 0;
  bit m_sticky = 1'b0;
  int n_resp = 0;

  // Requester state
  bit         rv  [NREQ];
  logic [3:0] rd  [NREQ];
  bit         acc [NREQ];
  bit gen_en = 1'b0;
  bit post_rst = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit aoi_model(input logic [3:0] d);
    return !((d[0] && d[1]) || (d[2] && d[3]));
  endfunction

  // Monitor: every response pulse is matched against the oldest expectation.
  exp_t e;
  always @(negedge clk) begin
    if (resp_valid != '0) begin
      if (q.size() == 0) begin
        chk("resp_unexpected", 32'(resp_valid), 32'd0);
      end else begin
        e = q.pop_front();
        n_resp++;
        if (e.mis) begin
          m_sticky = 1'b1;
          if (m_err < SAT) m_err++;
        end
        chk("resp_grant", 32'(resp_valid), 32'(1 << e.idx));
        chk("resp_data", 32'(resp_data), 32'(e.val));
        chk("resp_time", 32'(cyc), 32'(e.due));
        chk("err_cnt", 32'(err_cnt), 32'(m_err));
        chk("chk_err", 32'(chk_err), 32'(m_sticky));
      end
    end else if (q.size() > 0 && cyc > q[0].due) begin
      chk("resp_timeout", 32'(cyc), 32'(q[0].due));
      void'(q.pop_front());
    end
  end

  // One clock of stimulus: update requesters, drive, check ready/busy, log accepts.
  task automatic step(input bit do_rst);
    logic [NREQ-1:0] exp_rdy;
    logic [NREQ-1:0] v;
    logic [4*NREQ-1:0] dv;
    int w;
    bit idle;
    @(negedge clk);
    #1;
    if (post_rst) begin
      chk("rst_dp_in", 32'(dp_in), 32'd0);
      chk("rst_resp_data", 32'(resp_data), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_chk_err", 32'(chk_err), 32'd0);
      chk("rst_err_cnt", 32'(err_cnt), 32'd0);
      post_rst = 1'b0;
    end
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (!gen_en) rv[i] = 1'b0;
      else if (acc[i] || !rv[i]) begin
        rv[i] = ($urandom_range(1, 0) == 1);
        rd[i] = 4'($urandom);
      end else if ($urandom_range(7, 0) == 0) rv[i] = 1'b0;
      acc[i] = 1'b0;
    end
    for (int i = 0; i < NREQ; i++) begin
      v[i] = rv[i];
      dv[4*i +: 4] = rd[i];
    end
    rst = do_rst;
    req_valid = v;
    req_data = dv;
    #1;
    idle = (cyc + 1 >= free_edge);
    w = -1;
    for (int k = 1; k <= NREQ; k++) begin
      if (w < 0 && rv[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
    end
    exp_rdy = (idle && !do_rst && w >= 0) ? NREQ'(1 << w) : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("busy", 32'(busy), 32'(!idle));
    if (exp_rdy != '0) begin
      q.push_back('{idx: w, val: aoi_model(rd[w]) ^ inv, due: cyc + 1 + TLAT, mis: inv});
      m_ptr = w;
      free_edge = cyc + 1 + TLAT + 2;
      acc[w] = 1'b1;
    end
    if (do_rst) begin
      m_ptr = NREQ - 1;
      free_edge = 0;
      m_err = 0;
      m_sticky = 1'b0;
      q.delete();
      post_rst = 1'b1;
    end
  endtask

  // Wait for an accept, then reset in the following WAIT cycle.
  task automatic mid_reset();
    bit found;
    found = 1'b0;
    gen_en = 1'b1;
    for (int k = 0; k < 60; k++) begin
      step(1'b0);
      if (acc[0] || acc[1] || acc[2]) begin
        found = 1'b1;
        break;
      end
    end
    chk("mid_rst_accept_seen", 32'(found), 32'd1);
    step(1'b1);
  endtask

  // Stop new requests and let outstanding work complete.
  task automatic drain();
    bit ok;
    ok = 1'b0;
    gen_en = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step(1'b0);
      if (q.size() == 0 && cyc + 1 >= free_edge) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain", 32'(ok), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      rv[i] = 1'b0;
      rd[i] = 4'd0;
      acc[i] = 1'b0;
    end
    step(1'b1);
    step(1'b1);
    gen_en = 1'b1;
    repeat (300) step(1'b0);
    repeat (3) mid_reset();
    gen_en = 1'b1;
    repeat (100) step(1'b0);
    drain();
    inv = 1'b1;
    gen_en = 1'b1;
    repeat (150) step(1'b0);
    drain();
    chk("err_cnt_saturated", 32'(err_cnt), 32'(SAT));
    chk("chk_err_sticky", 32'(chk_err), 32'd1);
    inv = 1'b0;
    gen_en = 1'b1;
    repeat (100) step(1'b0);
    drain();
    chk("chk_err_holds", 32'(chk_err), 32'd1);
    mid_reset();
    gen_en = 1'b1;
    repeat (150) step(1'b0);
    drain();
    chk("responses_seen", 32'(n_resp > 20), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
